imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage of the RISC-V core. It decodes all base immediate formats (I, S, B, U, J) to XLEN bits, and optionally the CSR zimm format. A valid/ready handshake and a two-entry skid buffer sit in front of it, so a downstream execute-stage stall never creates a combinational ready path back to fetch. It replaces the single-cycle combinational sign extender in the decode datapath.

## Interface
Parameters:
- XLEN, 32, output datapath width; legal values are 32 and 64.
- TAG_W, 5, width of the opaque sideband tag (e.g. rd index or ROB id). The tag is carried alongside the immediate.

Ports:
- clk  in  1  clock. Everything is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  synchronous pipeline flush; discards all held entries.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_instr  in  32  full instruction word; bits [6:0] are ignored.
- in_immsrc  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR zimm), 110/111 reserved.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  decoded immediate.
- out_illegal  out  1  the format was reserved or disabled; out_imm is 0.
- out_tag  out  TAG_W  tag of the output beat.

## Operation
- Immediate formats (s = instr[31], replicated up to XLEN):
  - I: s, [30:20].
  - S: s, [30:25], [11:7].
  - B: s, [7], [30:25], [11:8], 0.
  - J: s, [19:12], [20], [30:21], 0.
  - U: s above bit 31, then [31:12], then 12 zeros.
  - Z: zero-extended [19:15].
- Reserved format (110/111, or 101 when Z is disabled):
  - out_imm = 0 and out_illegal = 1.
  - The beat is still transferred; it is not dropped.
- Storage is a main output register plus one skid register. Each holds {imm, illegal, tag, valid}.
- Transfer rules:
  - An input transfer happens when in_valid && in_ready.
  - An output transfer happens when out_valid && out_ready.
- State, encoded as {main_v, skid_v}: EMPTY (00), ONE (10), FULL (11). Transitions:
  - EMPTY + input → ONE.
  - ONE + input, no output → FULL; the new beat goes to skid.
  - ONE + input + output → ONE; main is overwritten with the new beat.
  - ONE + output only → EMPTY.
  - FULL + output → ONE; skid moves to main. No input is possible in FULL.
- in_ready = !skid_v && !rst. It is registered state only, with no path from out_ready.
- Ordering is strict FIFO; there is no reordering or bypass around main.
- flush:
  - Both valids go to 0 on the next edge. Any same-cycle input beat is discarded.
  - An output transfer asserted in the flush cycle still counts as consumed.
  - flush has priority over everything except rst.

## Timing
- Reset values: out_valid 0, out_imm 0, out_illegal 0, out_tag 0.
- in_ready is 0 during reset and 1 in the first cycle after rst deasserts.
- Latency: a beat accepted on edge N is visible on out_* in cycle N+1.
- Throughput: one beat per cycle with out_ready held high.
- Stall: with out_ready low, exactly 2 beats are accepted, then in_ready drops. After out_ready rises, in_ready returns 1 cycle later.
- out_* are held stable while out_valid && !out_ready.
- rst mid-transfer discards both entries; nothing is emitted afterwards.

## Configuration
- IMM_GEN_ZIMM_EN defined: format 101 produces the zero-extended zimm and out_illegal = 0.
- IMM_GEN_ZIMM_EN undefined: format 101 is treated as reserved (imm 0, illegal 1), and the Z decode logic is absent.

## Structure
- Package imm_gen_pkg holds:
  - typedef enum logic [2:0] immsrc_e (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z).
  - The XLEN legality check (elaboration-time assertion).
- Sub-module imm_decode: purely combinational. It maps (instr, immsrc) → (imm, illegal) and is parametrised by XLEN. It is instantiated once, ahead of the main/skid registers.
- Top-level imm_gen_pipe contains the handshake and skid logic.

## Test plan
- XLEN=32, out_ready=1: B-format instr 0xFE000EE3 → out_imm 0xFFFFFFFC, out_illegal 0, one cycle later.
- XLEN=64: U-format instr 0x800002B7 → 0xFFFFFFFF80000000. J-format instr 0x0080006F → 0x8.
- Reserved immsrc 111 with tag 0x1A → out_imm 0, out_illegal 1, out_tag 0x1A.
  - With IMM_GEN_ZIMM_EN: immsrc 101 with instr[19:15]=0x1F → imm 0x1F.
  - Without it: illegal.
- Backpressure: out_ready=0, stream 4 beats → 2 accepted and in_ready drops. Release out_ready → beats emerge in order with no loss or duplication.
- Flush while FULL, with in_valid=1 in the same cycle → out_valid=0 on the next cycle, and the input beat never appears.
- rst asserted while ONE → all outputs are 0 next cycle, and in_ready is 1 the cycle after rst deasserts.

Source files
------------

// File: rtl/imm_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pkg
// Description : Shared types and elaboration helpers for the pipelined
//               immediate generator (imm_decode, imm_gen_pipe).
// Revision    : 1.0 - initial release
// ============================================================================
package imm_gen_pkg;

    // Immediate format selector as driven by the decode control unit.
    // Codes 110 and 111 are reserved; 101 is only meaningful when the
    // CSR zimm decode is compiled in (IMM_GEN_ZIMM_EN).
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100,
        IMM_Z = 3'b101
    } immsrc_e;

    // Datapath widths the decoder supports; used by an elaboration-time
    // check in every module that takes XLEN.
    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage : imm_gen_pkg
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode
// Description : Purely combinational RISC-V immediate decoder. Maps the
//               instruction word and format select to an XLEN-bit immediate
//               plus an illegal flag for reserved/disabled formats.
//               Optional feature macro: IMM_GEN_ZIMM_EN (CSR zimm format).
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [2:0]      i_immsrc,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);

    // Reject unsupported datapath widths at elaboration.
    if (!xlen_legal(XLEN)) begin : g_xlen_bad
        $error("imm_decode: XLEN must be 32 or 64");
    end

    // Every format fits in 32 bits with its sign in bit 31; widening to XLEN
    // is then a single signed size cast. Zimm places a 0 in bit 31, so the
    // same cast yields zero extension for it.
    logic signed [31:0] w_imm32;
    logic               w_illegal;

    // Opcode bits never contribute to an immediate.
    logic w_unused;
    assign w_unused = ^i_instr[6:0];

    // Format select: assemble the 32-bit immediate for the chosen format.
    always_comb begin
        w_imm32   = '0;
        w_illegal = 1'b0;
        case (immsrc_e'(i_immsrc))
            IMM_I: w_imm32 = {{21{i_instr[31]}}, i_instr[30:20]};
            IMM_S: w_imm32 = {{21{i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
            IMM_B: w_imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25],
                              i_instr[11:8], 1'b0};
            IMM_J: w_imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20],
                              i_instr[30:21], 1'b0};
            IMM_U: w_imm32 = {i_instr[31:12], 12'd0};
`ifdef IMM_GEN_ZIMM_EN
            IMM_Z: w_imm32 = {27'd0, i_instr[19:15]};
`endif
            default: begin
                // Reserved (or compiled-out) format: beat still flows, flagged.
                w_imm32   = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

    assign o_imm     = XLEN'(w_imm32);
    assign o_illegal = w_illegal;

endmodule : imm_decode
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Pipelined immediate generator for the decode stage. A
//               combinational imm_decode feeds a main output register plus
//               one skid register behind a valid/ready handshake, so in_ready
//               depends on registered state only (no path from out_ready).
//               Optional feature macro: IMM_GEN_ZIMM_EN (CSR zimm format,
//               handled inside imm_decode).
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    // Reject unsupported datapath widths at elaboration.
    if (!xlen_legal(XLEN)) begin : g_xlen_bad
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    // Occupancy encoded as {main_v, skid_v}; 01 is never entered.
    localparam logic [1:0] c_st_empty = 2'b00;
    localparam logic [1:0] c_st_one   = 2'b10;
    localparam logic [1:0] c_st_full  = 2'b11;

    logic [XLEN-1:0]  w_dec_imm;
    logic             w_dec_ill;

    logic [XLEN-1:0]  r_main_imm;
    logic             r_main_ill;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_main_v;

    logic [XLEN-1:0]  r_skid_imm;
    logic             r_skid_ill;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_v;

    logic [1:0]       w_state;
    logic             w_in_fire;
    logic             w_out_fire;

    // Single decoder ahead of storage: both registers hold decoded beats.
    imm_decode #(
        .XLEN (XLEN)
    ) u_imm_decode (
        .i_instr   (in_instr),
        .i_immsrc  (in_immsrc),
        .o_imm     (w_dec_imm),
        .o_illegal (w_dec_ill)
    );

    assign w_state    = {r_main_v, r_skid_v};
    assign in_ready   = !r_skid_v && !rst;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_main_v && out_ready;

    // Main/skid occupancy and data movement; flush drops both entries but
    // leaves data untouched since it is only meaningful with a valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_imm <= '0;
            r_main_ill <= 1'b0;
            r_main_tag <= '0;
            r_main_v   <= 1'b0;
            r_skid_imm <= '0;
            r_skid_ill <= 1'b0;
            r_skid_tag <= '0;
            r_skid_v   <= 1'b0;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else begin
            case (w_state)
                c_st_empty: begin
                    if (w_in_fire) begin
                        r_main_imm <= w_dec_imm;
                        r_main_ill <= w_dec_ill;
                        r_main_tag <= in_tag;
                        r_main_v   <= 1'b1;
                    end
                end
                c_st_one: begin
                    if (w_in_fire && !w_out_fire) begin
                        // Downstream stalled: park the new beat behind main.
                        r_skid_imm <= w_dec_imm;
                        r_skid_ill <= w_dec_ill;
                        r_skid_tag <= in_tag;
                        r_skid_v   <= 1'b1;
                    end else if (w_in_fire) begin
                        // Main drains this cycle, so the new beat replaces it.
                        r_main_imm <= w_dec_imm;
                        r_main_ill <= w_dec_ill;
                        r_main_tag <= in_tag;
                    end else if (w_out_fire) begin
                        r_main_v <= 1'b0;
                    end
                end
                c_st_full: begin
                    // in_ready is low here; only the drain can happen.
                    if (w_out_fire) begin
                        r_main_imm <= r_skid_imm;
                        r_main_ill <= r_skid_ill;
                        r_main_tag <= r_skid_tag;
                        r_skid_v   <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: drop the orphaned skid entry.
                    r_skid_v <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = r_main_v;
    assign out_imm     = r_main_imm;
    assign out_illegal = r_main_ill;
    assign out_tag     = r_main_tag;

endmodule : imm_gen_pipe
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Self-checking bench for imm_gen_pipe. Drives an XLEN=32 and
//               an XLEN=64 instance from the same stimulus and checks both
//               against a queue-based reference model every cycle, plus
//               hand-computed literal expectations.
//               Honours IMM_GEN_ZIMM_EN for the zimm expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_instr = '0;
    logic [2:0]       in_immsrc = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_ready = 1'b0;

    logic             in_ready32, in_ready64;
    logic             out_valid32, out_valid64;
    logic [31:0]      out_imm32;
    logic [63:0]      out_imm64;
    logic             out_ill32, out_ill64;
    logic [TAG_W-1:0] out_tag32, out_tag64;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
        .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_illegal(out_ill32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
        .in_immsrc(in_immsrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_illegal(out_ill64), .out_tag(out_tag64)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode by plain arithmetic on field values: sign weight plus
    // each field times its bit position. Returns {illegal, imm64}.
    function automatic logic [64:0] mdec(input logic [31:0] ins, input logic [2:0] src);
        longint      sgn;
        logic [63:0] v;
        logic        ill;
        sgn = ins[31] ? -64'sd1 : 64'sd0;
        ill = 1'b0;
        case (src)
            3'd0: v = sgn * 2048 + ins[30:20];
            3'd1: v = sgn * 2048 + ins[30:25] * 32 + ins[11:7];
            3'd2: v = sgn * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2;
            3'd3: v = sgn * 1048576 + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2;
            3'd4: v = sgn * 64'sh1_0000_0000 + ins[31:12] * 4096;
`ifdef IMM_GEN_ZIMM_EN
            3'd5: v = 64'(ins[19:15]);
`endif
            default: begin v = '0; ill = 1'b1; end
        endcase
        return {ill, v};
    endfunction

    typedef struct {
        logic [63:0]      imm;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } beat_t;

    beat_t q[$];
    bit    clean  = 1'b0;
    bit    active = 1'b0;

    // Model: a FIFO of at most two decoded beats.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            clean  = 1'b1;
            active = 1'b1;
        end else if (active) begin
            bit    acc, pop;
            beat_t b;
            logic [64:0] d;
            acc = in_valid && (q.size() < 2);
            pop = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) q.delete(0);
                if (acc) begin
                    d     = mdec(in_instr, in_immsrc);
                    b.imm = d[63:0];
                    b.ill = d[64];
                    b.tag = in_tag;
                    q.push_back(b);
                    clean = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (active) begin
            chk("in_ready32", 64'(in_ready32), 64'(!rst && q.size() < 2));
            chk("in_ready64", 64'(in_ready64), 64'(!rst && q.size() < 2));
            chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
            chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("imm32", 64'(out_imm32), {32'd0, q[0].imm[31:0]});
                chk("imm64", out_imm64, q[0].imm);
                chk("ill32", 64'(out_ill32), 64'(q[0].ill));
                chk("ill64", 64'(out_ill64), 64'(q[0].ill));
                chk("tag32", 64'(out_tag32), 64'(q[0].tag));
                chk("tag64", 64'(out_tag64), 64'(q[0].tag));
            end else if (clean) begin
                chk("rst_imm64", out_imm64, 64'd0);
                chk("rst_imm32", 64'(out_imm32), 64'd0);
                chk("rst_ill", 64'({out_ill32, out_ill64}), 64'd0);
                chk("rst_tag", 64'({out_tag32, out_tag64}), 64'd0);
            end
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [2:0] src, input logic [TAG_W-1:0] tg);
        in_valid  = 1'b1;
        in_instr  = ins;
        in_immsrc = src;
        in_tag    = tg;
    endtask

    // Hold the driven beat until it is accepted; returns just after that edge.
    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready32) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [TAG_W-1:0] tg);
        drive(ins, src, tg);
        wait_accept();
    endtask

    logic [31:0]      tp_ins[8] = '{32'h00A00093, 32'hFFF00113, 32'h80000537, 32'hFE112E23,
                                   32'h7FFFF06F, 32'h00008663, 32'h8000006F, 32'h12345678};
    logic [2:0]       tp_src[8] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd3, 3'd2, 3'd3, 3'd6};

    initial begin
        logic [64:0] d;
        // Pin the model with hand-derived values.
        d = mdec(32'hFE000EE3, 3'd2); chk("model_B", d[63:0], 64'hFFFF_FFFF_FFFF_FFFC);
        d = mdec(32'h800002B7, 3'd4); chk("model_U", d[63:0], 64'hFFFF_FFFF_8000_0000);
        d = mdec(32'h0080006F, 3'd3); chk("model_J", d[63:0], 64'h8);
        d = mdec(32'hFFF00113, 3'd0); chk("model_I", d[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        d = mdec(32'hFE112E23, 3'd1); chk("model_S", d[63:0], 64'hFFFF_FFFF_FFFF_FFFC);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_in_ready", 64'(in_ready32), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready64), 64'd1);
        @(posedge clk); #1;

        // Formats with literal expectations, one-cycle latency.
        out_ready = 1'b1;
        send(32'hFE000EE3, 3'd2, 5'd3);
        @(negedge clk);
        chk("B32_valid", 64'(out_valid32), 64'd1);
        chk("B32_imm", 64'(out_imm32), 64'hFFFF_FFFC);
        chk("B32_ill", 64'(out_ill32), 64'd0);
        @(posedge clk); #1;
        send(32'h800002B7, 3'd4, 5'd4);
        @(negedge clk);
        chk("U64_imm", out_imm64, 64'hFFFF_FFFF_8000_0000);
        @(posedge clk); #1;
        send(32'h0080006F, 3'd3, 5'd5);
        @(negedge clk);
        chk("J64_imm", out_imm64, 64'h8);
        @(posedge clk); #1;
        send(32'hFFFFFFFF, 3'd7, 5'h1A);
        @(negedge clk);
        chk("rsv_imm", out_imm64, 64'd0);
        chk("rsv_ill", 64'(out_ill64), 64'd1);
        chk("rsv_tag", 64'(out_tag64), 64'h1A);
        @(posedge clk); #1;
        send(32'h000F8073, 3'd5, 5'd7);
        @(negedge clk);
`ifdef IMM_GEN_ZIMM_EN
        chk("Z_imm", out_imm64, 64'h1F);
        chk("Z_ill", 64'(out_ill64), 64'd0);
`else
        chk("Z_imm", out_imm64, 64'd0);
        chk("Z_ill", 64'(out_ill64), 64'd1);
`endif
        @(posedge clk); #1;

        // Back-to-back stream with out_ready high.
        for (int i = 0; i < 8; i++) send(tp_ins[i], tp_src[i], 5'(i + 8));
        repeat (2) @(posedge clk); #1;

        // Backpressure: two accepted, third held until drain.
        out_ready = 1'b0;
        send(32'h00100093, 3'd0, 5'd20);
        send(32'h00200093, 3'd0, 5'd21);
        drive(32'h00300093, 3'd0, 5'd22);
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready32), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready_same", 64'(in_ready32), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_in_ready_next", 64'(in_ready32), 64'd1);
        wait_accept();
        send(32'h00400093, 3'd0, 5'd23);
        repeat (3) @(posedge clk); #1;

        // Flush while FULL with a same-cycle input.
        out_ready = 1'b0;
        send(32'h00500093, 3'd0, 5'd24);
        send(32'h00600093, 3'd0, 5'd25);
        drive(32'h00700093, 3'd0, 5'd26);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_full_valid", 64'(out_valid64), 64'd0);
        @(posedge clk); #1;

        // Flush while ONE with an acceptable input: that beat is discarded.
        send(32'h00800093, 3'd0, 5'd27);
        drive(32'h00900093, 3'd0, 5'd28);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_one_valid", 64'(out_valid32), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Reset while ONE.
        out_ready = 1'b0;
        send(32'hABCDE0B7, 3'd4, 5'd29);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst1_valid", 64'(out_valid64), 64'd0);
        chk("rst1_imm", out_imm64, 64'd0);
        chk("rst1_tag", 64'(out_tag64), 64'd0);
        chk("rst1_in_ready", 64'(in_ready64), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst1_in_ready_after", 64'(in_ready64), 64'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_imm_gen_pipe
`default_nettype wire
